// File: rtl/bus_pkg.sv
// Shared constants for the bus responder: region selects, STATUS word
// layout and the value returned for unmapped reads.
package bus_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REGION_W = 20;

  // ADDR[31:12] values that select each region
  localparam logic [REGION_W-1:0] REGION_RAM    = 20'h00000;
  localparam logic [REGION_W-1:0] REGION_LED    = 20'h00001;
  localparam logic [REGION_W-1:0] REGION_TIMER  = 20'h00002;
  localparam logic [REGION_W-1:0] REGION_STATUS = 20'h00003;

  // STATUS word: {16'h0, cnt[7:0], 7'h0, err}
  localparam int unsigned STATUS_ERR_BIT   = 0;
  localparam int unsigned STATUS_CNT_LSB   = 8;
  localparam int unsigned STATUS_CNT_W     = 8;
  localparam int unsigned STATUS_CLEAR_BIT = 0;

  localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 32'h0;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_TIMER,
    SEL_STATUS,
    SEL_UNMAPPED
  } sel_e;

endpackage

// File: rtl/bus_ram.sv
// Single-clock word RAM, one read and one write port, read-first,
// registered read data, no reset on array or output.
//   clk   : clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : registered read data (old contents on same-address write)
module bus_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read-first: the read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped responder: address decode, RAM, LED register, free-running
// timer, sticky unmapped-access status, and registered read-data return.
// Optional feature macro: BUS_TIMER_EN (includes the TIMER region; when
// undefined, 0x00002xxx decodes as unmapped and no timer flops exist).
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   ADDR  : word address from the processor
//   DOUT  : write data from the processor
//   W     : write strobe
//   DIN   : read data, one cycle after ADDR is sampled
//   leds  : LED register
//   err   : sticky unmapped-access flag
module bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned LED_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              W,
  output logic [DATA_W-1:0] DIN,
  output logic [LED_W-1:0]  leds,
  output logic              err
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  sel_e                    sel_c;
  sel_e                    sel_q;
  logic [DATA_W-1:0]       rdata_c;
  logic [DATA_W-1:0]       rdata_q;
  logic [DATA_W-1:0]       ram_rdata;
  logic [STATUS_CNT_W-1:0] cnt_q;
  logic                    ram_we_c;
  logic                    unused_bits;

`ifdef BUS_TIMER_EN
  logic [DATA_W-1:0]       timer_q;
`endif

  // Only some address/data bits feed logic; fold the rest to keep them visible
  assign unused_bits = ^{ADDR, DOUT};

  // Region decode; every cycle is an access because ADDR is always valid
  always_comb begin
    sel_c = SEL_UNMAPPED;
    case (ADDR[31:12])
      REGION_RAM:    sel_c = SEL_RAM;
      REGION_LED:    sel_c = SEL_LED;
`ifdef BUS_TIMER_EN
      REGION_TIMER:  sel_c = SEL_TIMER;
`endif
      REGION_STATUS: sel_c = SEL_STATUS;
      default:       sel_c = SEL_UNMAPPED;
    endcase
  end

  // Register-side read data, captured with the pre-edge state of each source
  always_comb begin
    rdata_c = UNMAPPED_RDATA;
    case (sel_c)
      SEL_LED: rdata_c = DATA_W'(leds);
`ifdef BUS_TIMER_EN
      SEL_TIMER: rdata_c = timer_q;
`endif
      SEL_STATUS: begin
        rdata_c = '0;
        rdata_c[STATUS_CNT_LSB +: STATUS_CNT_W] = cnt_q;
        rdata_c[STATUS_ERR_BIT]                 = err;
      end
      default: rdata_c = UNMAPPED_RDATA;
    endcase
  end

  // Writes coinciding with reset are dropped; the array itself is never reset
  assign ram_we_c = rst_n && W && (sel_c == SEL_RAM);

  bus_ram #(
    .DEPTH (MEM_DEPTH),
    .DW    (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ADDR[AW-1:0]),
    .wdata (DOUT),
    .raddr (ADDR[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Region select, register read data, LED and status state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= SEL_UNMAPPED;
      rdata_q <= '0;
      leds    <= '0;
      err     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sel_q   <= sel_c;
      rdata_q <= rdata_c;
      if (W && sel_c == SEL_LED) leds <= DOUT[LED_W-1:0];
      if (sel_c == SEL_UNMAPPED) begin
        err <= 1'b1;
        if (cnt_q != {STATUS_CNT_W{1'b1}}) cnt_q <= cnt_q + STATUS_CNT_W'(1);
      end else if (W && sel_c == SEL_STATUS && DOUT[STATUS_CLEAR_BIT]) begin
        err   <= 1'b0;
        cnt_q <= '0;
      end
    end
  end

`ifdef BUS_TIMER_EN
  // A write makes DOUT the value of the write cycle, so the counter
  // already shows DOUT+1 on the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n)                      timer_q <= '0;
    else if (W && sel_c == SEL_TIMER) timer_q <= DOUT + DATA_W'(1);
    else                             timer_q <= timer_q + DATA_W'(1);
  end
`endif

  // Both mux inputs are flops; the select is the registered region
  assign DIN = (sel_q == SEL_RAM) ? ram_rdata : rdata_q;

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit RAM words (power of two, 16..4096).
REQ-002 SHALL have parameter LED_W, default 16, width of the LED output register (1..32).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ADDR  input  32  word address from the processor, registered on the processor side.
REQ-006 SHALL have port DOUT  input  32  write data from the processor.
REQ-007 SHALL have port W  input  1  write strobe; 1 = write on this edge.
REQ-008 SHALL have port DIN  output  32  registered read data to the processor.
REQ-009 SHALL have port leds  output  LED_W  LED register contents.
REQ-010 SHALL have port err  output  1  sticky unmapped-access flag.

Function
REQ-011 SHALL decode ADDR[31:12]: 0x00000 RAM, 0x00001 LED, 0x00002 TIMER, 0x00003 STATUS, all other values UNMAPPED.
REQ-012 SHALL index RAM with ADDR[$clog2(MEM_DEPTH)-1:0]; ADDR[11:$clog2(MEM_DEPTH)] ignored (aliasing).
REQ-013 SHALL sample ADDR, DOUT and W on every rising edge; a write takes effect at that edge when W=1.
REQ-014 SHALL present read data on DIN one cycle after ADDR is sampled, whether W is 0 or 1.
REQ-015 SHALL return old data on read-during-write to the same RAM word (read-first).
REQ-016 LED write SHALL store DOUT[LED_W-1:0]; LED read SHALL return leds zero-extended.
REQ-017 TIMER SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0x00000000.
REQ-018 TIMER write SHALL load DOUT; the next cycle resumes counting from DOUT+1.
REQ-019 TIMER read SHALL return the counter value held before the sampling edge.
REQ-020 STATUS read SHALL return {16'h0, cnt[7:0], 7'h0, err}, where cnt is the unmapped-access count.
REQ-021 STATUS write with DOUT[0]=1 SHALL clear err and cnt; DOUT[0]=0 SHALL have no effect.
REQ-022 An UNMAPPED access, read or write, SHALL set err, increment cnt saturating at 255, and return DIN=0; write data is discarded.
REQ-023 Any region decoded while the processor is idle SHALL be treated as an access; the processor holds ADDR stable, so repeated cycles on an unmapped address count once per cycle.
REQ-024 Writes SHALL never alter DIN in the same cycle; DIN changes only on the edge following the sampled address.

Reset
REQ-025 With rst_n=0 at an edge: DIN=0, leds=0, err=0, cnt=0, timer=0.
REQ-026 A write coinciding with a reset edge SHALL be dropped; RAM contents SHALL NOT be reset.
REQ-027 After rst_n rises, the first edge SHALL behave as a normal access; timer reads 0 on that first read.

Configuration
REQ-028 Macro BUS_TIMER_EN defined SHALL include the TIMER region per REQ-017..019.
REQ-029 Macro BUS_TIMER_EN undefined SHALL remove the timer flops and treat 0x00002xxx as UNMAPPED per REQ-022.

Structure
REQ-030 Package bus_pkg SHALL hold region select constants (RAM/LED/TIMER/STATUS), STATUS bit positions, and the unmapped read value 32'h0.
REQ-031 RAM SHALL be a sub-module bus_ram: 1 read and 1 write port, read-first, registered output, no reset.
REQ-032 Decode, LED, timer, status and DIN mux SHALL live in bus_responder.

Verification
REQ-033 Write RAM at 0x5 with 0xCAFEF00D, then read 0x5: DIN=0xCAFEF00D one cycle after the read address; read 0x105 (MEM_DEPTH=256) also returns 0xCAFEF00D.
REQ-034 Write and read the same cycle at 0x7, which holds 0x11, with DOUT=0x22: DIN=0x11, and the next read returns 0x22.
REQ-035 Write LED with 0xFFFF1234: leds=0x1234 and the LED read returns 0x00001234.
REQ-036 Write TIMER with 0xFFFFFFFE, then read for 3 consecutive cycles: DIN=0xFFFFFFFF, 0x00000000, 0x00000001. Without BUS_TIMER_EN: DIN=0 and err=1.
REQ-037 Read 0x00009000 for 300 cycles: err=1, STATUS read=0x0000FF01; write STATUS with 0x1: STATUS read=0x00000000.
REQ-038 Assert reset mid-stream with W=1 to LED at 0xAAAA: leds=0, err=0, DIN=0, and the LED write is lost.
